// File: rtl/rca_chunk_seq.sv
// Multi-cycle W=N*M bit adder time-sharing one N-bit ripple adder, LSB chunk first; optional signed overflow via RCA_SEQ_SIGNED_OVF_EN.
// Latency: start accepted at edge k, busy for M cycles, done pulse in cycle k+M+1; minimum issue period M+2.
// Backpressure: none queued; start is only sampled in IDLE and ignored while busy or done.

module rca_nbit_mux #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic c;

    // Carry-select per bit: propagate passes the incoming carry, otherwise a==b decides it.
    always_comb begin
        c   = cin;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] ^ b[i]) ? c : a[i];
        end
        cout = c;
    end
endmodule

module rca_chunk_seq #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N*M-1:0]   a,
    input  logic [N*M-1:0]   b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [N*M-1:0]   sum,
    output logic             cout
`ifdef RCA_SEQ_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int W  = N * M;
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    opa;
    logic [W-1:0]    opb;
    logic [W-1:0]    result;
    logic [W-1:0]    result_nxt;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    add_sum;
    logic            add_cout;
    logic            accept;
    logic            last;

    rca_nbit_mux #(.N(N)) u_add (
        .a    (opa[N-1:0]),
        .b    (opb[N-1:0]),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(M - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Completed result including the chunk produced this cycle, so the final edge can load sum directly.
    always_comb begin
        result_nxt = result;
        result_nxt[int'(cnt) * N +: N] = add_sum;
    end

`ifdef RCA_SEQ_SIGNED_OVF_EN
    logic sa;
    logic sb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa  <= 1'b0;
            sb  <= 1'b0;
            ovf <= 1'b0;
        end else if (accept) begin
            sa <= a[W-1];
            sb <= b[W-1];
        end else if (last) begin
            ovf <= (sa == sb) && (result_nxt[W-1] != sa);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            result <= result_nxt;
            carry  <= add_cout;
            opa    <= opa >> N;
            opb    <= opb >> N;
            if (last) begin
                sum  <= result_nxt;
                cout <= add_cout;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_rca_chunk_seq.sv
// Randomized and directed bench for rca_chunk_seq against an arithmetic reference model.
module tb_rca_chunk_seq;
    localparam int N = 4;
    localparam int M = 4;
    localparam int W = N * M;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef RCA_SEQ_SIGNED_OVF_EN
    logic         ovf;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [W-1:0] prev_sum  = '0;
    logic         prev_cout = 1'b0;
    logic         prev_ovf  = 1'b0;

    rca_chunk_seq #(.N(N), .M(M)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef RCA_SEQ_SIGNED_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full operation; inputs are scrambled after capture to prove they are ignored.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input string tag);
        logic [W:0] exp_full;
        int         sv;
        logic       exp_ovf;
        exp_full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        sv       = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
        exp_ovf  = (sv > (2 ** (W - 1)) - 1) || (sv < -(2 ** (W - 1)));
        start = 1'b1;
        a     = ta;
        b     = tb;
        cin   = tc;
        @(posedge clk); #1;
        for (int i = 0; i < M; i++) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_nodone"}, done, 0);
            chk({tag, "_sumhold"}, sum, prev_sum);
            chk({tag, "_couthold"}, cout, prev_cout);
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            start = 1'($urandom);
            @(posedge clk); #1;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy0"}, busy, 0);
        chk({tag, "_sum"}, sum, exp_full[W-1:0]);
        chk({tag, "_cout"}, cout, exp_full[W]);
`ifdef RCA_SEQ_SIGNED_OVF_EN
        chk({tag, "_ovf"}, ovf, exp_ovf);
`endif
        prev_sum  = exp_full[W-1:0];
        prev_cout = exp_full[W];
        prev_ovf  = exp_ovf;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_idle_done"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_sum"}, sum, prev_sum);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(16'h00FF, 16'h0001, 1'b0, "ripple");
        run_op(16'hFFFF, 16'h0001, 1'b0, "wrap");
        run_op(16'h7FFF, 16'h0001, 1'b0, "sovf_pos");
        run_op(16'h8000, 16'h8000, 1'b0, "sovf_neg");
        run_op(16'h1234, 16'h4321, 1'b1, "cin_cap");
        run_op(16'hFFFF, 16'hFFFF, 1'b1, "allones");

        // Reset during the second busy cycle discards the operation.
        start = 1'b1;
        a     = 16'hABCD;
        b     = 16'h1111;
        cin   = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        prev_sum  = '0;
        prev_cout = 1'b0;
        prev_ovf  = 1'b0;
        for (int i = 0; i < M + 3; i++) begin
            chk("post_rst_nodone", done, 0);
            @(posedge clk); #1;
        end
        run_op(16'h0F0F, 16'h00F1, 1'b0, "after_rst");

        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), "rand");
        end

        // Start held high: accepts every M+2 cycles.
        start = 1'b1;
        a     = 16'h0001;
        b     = 16'h0001;
        cin   = 1'b0;
        @(posedge clk); #1;
        for (int j = 0; j < 3 * (M + 2); j++) begin
            int ph;
            ph = j % (M + 2);
            chk("held_busy", busy, (ph < M) ? 1 : 0);
            chk("held_done", done, (ph == M) ? 1 : 0);
            chk("held_sum", sum, (j >= M) ? 32'h0002 : 32'(prev_sum));
            @(posedge clk); #1;
        end
        start = 1'b0;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/rca_chunk_seq.md
Name: rca_chunk_seq

Overview:
Multi-cycle sequencer that adds two W-bit operands (W = N*M) by time-sharing one N-bit rca_nbit_mux instance over M cycles, one N-bit chunk per cycle, LSB chunk first. It holds the inter-chunk carry in a register and builds the result chunk by chunk. A start/busy/done handshake is used, so a narrow adder can serve wide operands in the Lab2 datapath.

Parameters:
N, 4, chunk width; width of the internal rca_nbit_mux instance (N >= 1).
M, 4, number of chunks per operation (M >= 1); operand width W = N*M.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  request; sampled only in IDLE.
a  in  W  operand A; captured on the accepted start.
b  in  W  operand B; captured on the accepted start.
cin  in  1  carry-in to chunk 0; captured on the accepted start.
busy  out  1  high while in RUN.
done  out  1  one-cycle pulse; sum/cout are valid from this cycle on.
sum  out  W  registered result; holds until the next done.
cout  out  1  registered carry-out of chunk M-1; holds like sum.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sum=0, cout=0; operand regs, carry reg, result reg and counter cleared. Takes effect immediately mid-operation; any in-flight add is discarded with no done.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge -> capture a, b into operand shift regs and cin into carry reg; cnt<=0; go RUN.
  - start=0 -> stay in IDLE.
- RUN (busy=1):
  - Adder inputs: a=opA[N-1:0], b=opB[N-1:0], cin=carry reg.
  - At each edge: result[cnt*N +: N] <= adder sum; carry <= adder cout; opA/opB shift right by N; cnt++.
  - When cnt==M-1 at the edge -> go DONE, loading sum<=completed result and cout<=final adder cout.
- DONE: done=1 and busy=0 for exactly one cycle; then IDLE unconditionally.
- start is ignored in RUN and DONE. No queuing: start must be high in IDLE to be accepted.
- Latency: start accepted at edge k; busy high in cycles k+1..k+M; done high in cycle k+M+1. Minimum issue period is M+2 cycles.
- sum/cout keep the previous result throughout RUN; they change only on the RUN->DONE edge.
- Changing a/b/cin after capture has no effect on the operation in flight.
- Arithmetic: unsigned W-bit add; {cout,sum} = a + b + cin, modulo 2^(W+1). Carry propagates across chunks only through the carry reg.
- M=1: a single RUN cycle; done at k+2.
- cnt is ceil(log2(M)) bits (minimum 1). It never wraps within an operation and is reset to 0 on each accept.

Optional Feature:
Macro RCA_SEQ_SIGNED_OVF_EN.
- Defined: adds output port ovf (1 bit, registered, reset 0). On accept, the sign bits a[W-1] and b[W-1] are captured. On the RUN->DONE edge, ovf <= (sa==sb) && (sum[W-1]!=sa), i.e. two's-complement W-bit overflow. ovf holds with sum.
- Undefined: ovf port and sign-capture logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-RUN (N=4, M=4): rst=1 during the 2nd busy cycle -> busy=0, done=0, sum=0, cout=0 immediately; no done pulse follows; the next start works normally.
- Chunk carry ripple: a=16'h00FF, b=16'h0001, cin=0, start at edge k -> busy in k+1..k+4, done at k+5, sum=16'h0100, cout=0.
- Full wrap: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1. With macro: ovf=0.
- Signed overflow: a=16'h7FFF, b=16'h0001 -> sum=16'h8000, cout=0. With macro: ovf=1. Also a=16'h8000, b=16'h8000 -> sum=16'h0000, cout=1, ovf=1.
- Carry-in and operand capture: a=16'h1234, b=16'h4321, cin=1; change a to 16'hFFFF in cycle k+2 -> sum=16'h5556, cout=0.
- Start held high continuously with a=16'h0001, b=16'h0001: operations are accepted at k, k+6, k+12 (period M+2); each gives done with sum=16'h0002. sum holds 16'h0002 between done pulses.
